// File: rtl/delay_align_scheduler.sv
// delay_align_scheduler
// Sequences an auto-alignment sweep across a bank of delay-control lanes.
// Each selected lane gets its auto-mode request raised, the scheduler waits
// for the lane's ready flag to cycle low then high, grades the reported eye
// width, and releases the lane. Failed attempts are retried a bounded number
// of times before the lane is flagged as failed.
// LW must be wide enough to index every lane (2**LW >= N_LANES).

module delay_align_scheduler #(
    parameter int N_LANES   = 8,
    parameter int MAX_RETRY = 2,
    parameter int LW        = 4
) (
    input  logic                   clk160,
    input  logic                   rstb,
    input  logic                   start,
    input  logic [N_LANES-1:0]     lane_mask,
    input  logic [5:0]             min_eye_width,
    input  logic [15:0]            timeout_cfg,
    input  logic [N_LANES-1:0]     lane_delay_ready,
    input  logic [6*N_LANES-1:0]   lane_eye_width,
    output logic [N_LANES-1:0]     lane_delay_mode,
    output logic                   busy,
    output logic                   done,
    output logic [LW-1:0]          cur_lane,
    output logic [N_LANES-1:0]     lane_aligned,
    output logic [N_LANES-1:0]     lane_failed
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_WAIT_READY,
        S_CHECK,
        S_RELEASE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [N_LANES-1:0]   pending;
    logic [15:0]          timer;
    logic [RW-1:0]        retry_cnt;
    logic [1:0]           rel_cnt;
    logic                 attempt_ok;

    // Per-lane views of the lane currently being serviced.
    logic [N_LANES-1:0]   lane_sel;
    logic                 ready_cur;
    logic [5:0]           eye_cur;
    logic                 pend_cur;

    logic                 timed_out;
    logic                 eye_ok;
    logic                 last_lane;
    logic                 retry_left;

    // Strobes from the FSM to the datapath.
    logic                 accept;
    logic                 timer_clr;
    logic                 fail_now;
    logic                 retry_inc;
    logic                 mark_fail;
    logic                 advance;

    // Select the serviced lane's ready flag, eye width and pending bit.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        lane_sel  = '0;
        ready_cur = 1'b0;
        eye_cur   = '0;
        pend_cur  = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            if (cur_lane == LW'(i)) begin
                lane_sel[i] = 1'b1;
                ready_cur   = lane_delay_ready[i];
                eye_cur     = lane_eye_width[6*i +: 6];
                pend_cur    = pending[i];
            end
        end
    end

    assign timed_out  = (timer == timeout_cfg);
    assign eye_ok     = (eye_cur >= min_eye_width);
    assign last_lane  = (cur_lane == LW'(N_LANES - 1));
    assign retry_left = (retry_cnt < RW'(MAX_RETRY));

    // State register; reset is sampled on the clock edge and beats start.
    always_ff @(posedge clk160) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rstb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath strobes; the timeout has priority over ready.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        timer_clr = 1'b0;
        fail_now  = 1'b0;
        retry_inc = 1'b0;
        mark_fail = 1'b0;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (pend_cur) begin
                    timer_clr = 1'b1;
                    state_nxt = S_ARM;
                end else begin
                    state_nxt = S_NEXT;
                end
            end
            S_ARM: begin
                if (timed_out) begin
                    fail_now  = 1'b1;
                    state_nxt = S_RELEASE;
                end else if (!ready_cur) begin
                    timer_clr = 1'b1;
                    state_nxt = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (timed_out) begin
                    fail_now  = 1'b1;
                    state_nxt = S_RELEASE;
                end else if (ready_cur) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (rel_cnt == 2'd3) begin
                    if (attempt_ok) begin
                        state_nxt = S_NEXT;
                    end else if (retry_left) begin
                        retry_inc = 1'b1;
                        state_nxt = S_SELECT;
                    end else begin
                        mark_fail = 1'b1;
                        state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (last_lane) begin
                    state_nxt = S_DONE;
                end else begin
                    advance   = 1'b1;
                    state_nxt = S_SELECT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sweep bookkeeping: pending lanes, timer, retry and release counters, result flags.
    always_ff @(posedge clk160) begin
        if (!rstb) begin
            pending      <= '0;
            timer        <= '0;
            retry_cnt    <= '0;
            rel_cnt      <= '0;
            attempt_ok   <= 1'b0;
            cur_lane     <= '0;
            lane_aligned <= '0;
            lane_failed  <= '0;
        end else begin
            if (accept) begin
                pending      <= lane_mask;
                lane_aligned <= '0;
                lane_failed  <= '0;
                cur_lane     <= '0;
                retry_cnt    <= '0;
            end

            if (timer_clr) begin
                timer <= '0;
            end else if ((state == S_ARM || state == S_WAIT_READY) && timer != 16'hFFFF) begin
                timer <= timer + 16'd1;
            end

            // Release lasts exactly four cycles: rel_cnt walks 0..3 while in RELEASE.
            rel_cnt <= (state == S_RELEASE) ? rel_cnt + 2'd1 : 2'd0;

            if (state == S_CHECK) begin
                attempt_ok <= eye_ok;
                if (eye_ok) begin
                    lane_aligned <= lane_aligned | lane_sel;
                end
            end
            if (fail_now) begin
                attempt_ok <= 1'b0;
            end

            if (retry_inc) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            if (mark_fail) begin
                lane_failed <= lane_failed | lane_sel;
            end

            if (state == S_NEXT) begin
                retry_cnt <= '0;
            end
            if (advance) begin
                cur_lane <= cur_lane + LW'(1);
            end
        end
    end

    // The auto-mode request is decoded from state, so it can only be high in ARM or WAIT_READY.
    assign lane_delay_mode = (state == S_ARM || state == S_WAIT_READY) ? lane_sel : '0;
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_DONE);

endmodule

// File: tb/tb_delay_align_scheduler.sv
// Directed testbench for delay_align_scheduler with a simple behavioural
// model of each lane's delay controller.

module tb_delay_align_scheduler;

    logic        clk160 = 1'b0;
    logic        rstb = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  lane_mask = 8'h00;
    logic [5:0]  min_eye_width = 6'd4;
    logic [15:0] timeout_cfg = 16'd1000;
    logic [7:0]  model_ready = 8'hFF;
    logic [47:0] lane_eye_width;
    logic [7:0]  lane_delay_mode;
    logic        busy;
    logic        done;
    logic [3:0]  cur_lane;
    logic [7:0]  lane_aligned;
    logic [7:0]  lane_failed;

    logic [5:0]  eye_val [8];
    logic [7:0]  stuck = 8'h00;
    int          mcnt [8];

    int          n_checks = 0;
    int          n_fail = 0;

    // Monitor state
    int          arm_cnt [8];
    int          run_len [8];
    int          last_len [8];
    int          onehot_err;
    int          done_cnt;
    int          seq [$];
    logic [7:0]  prev_mode = 8'h00;

    delay_align_scheduler #(
        .N_LANES   (8),
        .MAX_RETRY (2),
        .LW        (4)
    ) dut (
        .clk160           (clk160),
        .rstb             (rstb),
        .start            (start),
        .lane_mask        (lane_mask),
        .min_eye_width    (min_eye_width),
        .timeout_cfg      (timeout_cfg),
        .lane_delay_ready (model_ready),
        .lane_eye_width   (lane_eye_width),
        .lane_delay_mode  (lane_delay_mode),
        .busy             (busy),
        .done             (done),
        .cur_lane         (cur_lane),
        .lane_aligned     (lane_aligned),
        .lane_failed      (lane_failed)
    );

    always #5 clk160 = ~clk160;

    always_comb begin
        lane_eye_width = '0;
        for (int i = 0; i < 8; i++) lane_eye_width[6*i +: 6] = eye_val[i];
    end

    // Lane model: ready idles high; drops 3 cycles after mode rises, rises 200 cycles later.
    always @(posedge clk160) begin
        for (int i = 0; i < 8; i++) begin
            if (!lane_delay_mode[i]) begin
                mcnt[i]        <= 0;
                model_ready[i] <= 1'b1;
            end else begin
                mcnt[i] <= mcnt[i] + 1;
                if (!stuck[i]) begin
                    if (mcnt[i] == 2) model_ready[i] <= 1'b0;
                    else if (mcnt[i] == 202) model_ready[i] <= 1'b1;
                end
            end
        end
    end

    // Observe mode requests and done pulses on the falling edge.
    always @(negedge clk160) begin
        for (int i = 0; i < 8; i++) begin
            if (lane_delay_mode[i] === 1'b1 && prev_mode[i] !== 1'b1) begin
                arm_cnt[i] = arm_cnt[i] + 1;
                seq.push_back(i);
            end
            if (lane_delay_mode[i] === 1'b1) begin
                run_len[i] = run_len[i] + 1;
            end else if (prev_mode[i] === 1'b1) begin
                last_len[i] = run_len[i];
                run_len[i]  = 0;
            end
        end
        if ($countones(lane_delay_mode) > 1) onehot_err = onehot_err + 1;
        if (done === 1'b1) done_cnt = done_cnt + 1;
        prev_mode = lane_delay_mode;
    end

    task automatic clear_monitor();
        for (int i = 0; i < 8; i++) begin
            arm_cnt[i]  = 0;
            run_len[i]  = 0;
            last_len[i] = 0;
        end
        onehot_err = 0;
        done_cnt   = 0;
        seq.delete();
    endtask

    task automatic set_lanes(input logic [5:0] eye);
        for (int i = 0; i < 8; i++) eye_val[i] = eye;
        stuck = 8'h00;
    endtask

    task automatic start_sweep(input logic [7:0] mask);
        @(posedge clk160);
        #1;
        lane_mask = mask;
        start     = 1'b1;
        @(posedge clk160);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk160);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL sweep_done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic settle_and_check_end(input string tag);
        repeat (5) @(negedge clk160);
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_after: got %b expected 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rstb      = 1'b0;
        start     = 1'b1;
        lane_mask = 8'hFF;
        repeat (3) @(posedge clk160);
        @(negedge clk160);
        n_checks++;
        if ({lane_delay_mode, busy, done, cur_lane, lane_aligned, lane_failed} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: mode=%h busy=%b done=%b lane=%0d al=%h fl=%h expected all 0",
                     lane_delay_mode, busy, done, cur_lane, lane_aligned, lane_failed);
        end
        rstb  = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk160);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overrides_start: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_zero_mask();
        int lat;
        clear_monitor();
        start_sweep(8'h00);
        wait_done(100, lat);
        n_checks++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL zero_mask_latency: got %0d expected 17", lat);
        end
        n_checks++;
        if (cur_lane !== 4'd7) begin
            n_fail++;
            $display("FAIL zero_mask_cur_lane: got %0d expected 7", cur_lane);
        end
        n_checks++;
        if (seq.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_mask_no_mode: got %0d arms expected 0", seq.size());
        end
        settle_and_check_end("zero_mask");
    endtask

    task automatic test_nominal();
        int lat;
        set_lanes(6'd10);
        min_eye_width = 6'd4;
        timeout_cfg   = 16'd1000;
        clear_monitor();
        start_sweep(8'hFF);
        @(negedge clk160);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_busy: got %b expected 1", busy);
        end
        wait_done(4000, lat);
        settle_and_check_end("nominal");
        n_checks++;
        if (seq.size() !== 8) begin
            n_fail++;
            $display("FAIL nominal_arm_total: got %0d expected 8", seq.size());
        end
        for (int i = 0; i < 8 && i < seq.size(); i++) begin
            n_checks++;
            if (seq[i] !== i) begin
                n_fail++;
                $display("FAIL nominal_order[%0d]: got lane %0d expected %0d", i, seq[i], i);
            end
        end
        n_checks++;
        if (onehot_err !== 0) begin
            n_fail++;
            $display("FAIL nominal_onehot: got %0d violations expected 0", onehot_err);
        end
        n_checks++;
        if (lane_aligned !== 8'hFF || lane_failed !== 8'h00) begin
            n_fail++;
            $display("FAIL nominal_result: al=%h fl=%h expected al=ff fl=00", lane_aligned, lane_failed);
        end
    endtask

    task automatic test_narrow_eye();
        int lat;
        set_lanes(6'd10);
        eye_val[2] = 6'd2;
        eye_val[6] = 6'd4;
        clear_monitor();
        start_sweep(8'hFF);
        wait_done(5000, lat);
        settle_and_check_end("narrow");
        n_checks++;
        if (arm_cnt[2] !== 3) begin
            n_fail++;
            $display("FAIL narrow_lane2_arms: got %0d expected 3", arm_cnt[2]);
        end
        n_checks++;
        if (arm_cnt[6] !== 1) begin
            n_fail++;
            $display("FAIL narrow_lane6_arms: got %0d expected 1", arm_cnt[6]);
        end
        n_checks++;
        if (lane_failed !== 8'h04) begin
            n_fail++;
            $display("FAIL narrow_failed: got %h expected 04", lane_failed);
        end
        n_checks++;
        if (lane_aligned !== 8'hFB) begin
            n_fail++;
            $display("FAIL narrow_aligned: got %h expected fb", lane_aligned);
        end
    endtask

    task automatic test_stale_ready();
        int lat;
        set_lanes(6'd10);
        stuck[5]    = 1'b1;
        timeout_cfg = 16'd100;
        clear_monitor();
        start_sweep(8'h20);
        wait_done(2000, lat);
        settle_and_check_end("stale");
        n_checks++;
        if (arm_cnt[5] !== 3) begin
            n_fail++;
            $display("FAIL stale_arms: got %0d expected 3", arm_cnt[5]);
        end
        n_checks++;
        if (last_len[5] !== 101) begin
            n_fail++;
            $display("FAIL stale_arm_length: got %0d expected 101", last_len[5]);
        end
        n_checks++;
        if (lane_failed !== 8'h20 || lane_aligned !== 8'h00) begin
            n_fail++;
            $display("FAIL stale_result: fl=%h al=%h expected fl=20 al=00", lane_failed, lane_aligned);
        end
        stuck[5]    = 1'b0;
        timeout_cfg = 16'd1000;
    endtask

    task automatic test_sparse_mask();
        int lat;
        set_lanes(6'd10);
        clear_monitor();
        start_sweep(8'h81);
        repeat (50) @(negedge clk160);
        start_sweep(8'hFF);
        wait_done(3000, lat);
        settle_and_check_end("sparse");
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (arm_cnt[i] !== ((i == 0 || i == 7) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL sparse_arms[%0d]: got %0d expected %0d", i, arm_cnt[i],
                         (i == 0 || i == 7) ? 1 : 0);
            end
        end
        n_checks++;
        if (lane_aligned !== 8'h81) begin
            n_fail++;
            $display("FAIL sparse_aligned: got %h expected 81", lane_aligned);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int  lat;
        bit  found;
        set_lanes(6'd10);
        clear_monitor();
        start_sweep(8'hFF);
        found = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk160);
            if (lane_delay_mode[3] === 1'b1 && model_ready[3] === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midreset_reach_lane3: lane 3 never reached WAIT_READY");
        end
        repeat (10) @(negedge clk160);
        n_checks++;
        if (lane_aligned !== 8'h07) begin
            n_fail++;
            $display("FAIL midreset_pre_aligned: got %h expected 07", lane_aligned);
        end
        rstb = 1'b0;
        @(posedge clk160);
        #1;
        n_checks++;
        if ({lane_delay_mode, busy, done, cur_lane, lane_aligned, lane_failed} !== 30'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: mode=%h busy=%b done=%b lane=%0d al=%h fl=%h expected all 0",
                     lane_delay_mode, busy, done, cur_lane, lane_aligned, lane_failed);
        end
        @(negedge clk160);
        rstb = 1'b1;
        repeat (3) @(negedge clk160);
        clear_monitor();
        start_sweep(8'hFF);
        wait_done(4000, lat);
        settle_and_check_end("midreset");
        n_checks++;
        if (seq.size() < 1 || seq[0] !== 0) begin
            n_fail++;
            $display("FAIL midreset_restart_lane0: first armed lane %0d expected 0",
                     (seq.size() > 0) ? seq[0] : -1);
        end
        n_checks++;
        if (lane_aligned !== 8'hFF) begin
            n_fail++;
            $display("FAIL midreset_aligned: got %h expected ff", lane_aligned);
        end
    endtask

    task automatic test_timeout_zero();
        int lat;
        set_lanes(6'd10);
        timeout_cfg = 16'd0;
        clear_monitor();
        start_sweep(8'h01);
        wait_done(500, lat);
        settle_and_check_end("tmo0");
        n_checks++;
        if (arm_cnt[0] !== 3) begin
            n_fail++;
            $display("FAIL tmo0_arms: got %0d expected 3", arm_cnt[0]);
        end
        n_checks++;
        if (last_len[0] !== 1) begin
            n_fail++;
            $display("FAIL tmo0_arm_length: got %0d expected 1", last_len[0]);
        end
        n_checks++;
        if (lane_failed !== 8'h01 || lane_aligned !== 8'h00) begin
            n_fail++;
            $display("FAIL tmo0_result: fl=%h al=%h expected fl=01 al=00", lane_failed, lane_aligned);
        end
        timeout_cfg = 16'd1000;
    endtask

    initial begin
        set_lanes(6'd10);
        clear_monitor();
        test_reset();
        test_zero_mask();
        test_nominal();
        test_narrow_eye();
        test_stale_ready();
        test_sparse_mask();
        test_reset_mid_sweep();
        test_timeout_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
